pwm_pr_multi: RTL
=================

Name: pwm_pr_multi

Overview:
Multi-channel PWM modulator with a selectable ordering mode: conventional ramp, or bit-reversed pseudo-random fill that pushes spectral energy towards higher frequencies.
- Generalised in channel count and resolution.
- Adds a full-scale (100 %) duty code and glitch-free double-buffered duty updates through a valid/ready write port.
- Optional per-channel phase staggering to spread switching edges.
- Sits between control logic (CPU registers, LED/audio engines) and output pins.

Parameters:
CHANNELS, 4, number of PWM outputs; power of 2, >= 2
BITS, 4, counter width; period P = 2^BITS states
STAGGER, 0, 1 = channel k counter offset by k*(P/CHANNELS); requires CHANNELS <= P

Ports:
clk  in  1  PWM clock
rst  in  1  synchronous reset, active-high
wr_data  in  BITS+1  duty code, unsigned; 0 = always off, P = always on, >P saturates to P
wr_ch  in  clog2(CHANNELS)  target channel of write
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid & wr_ready
mode  in  1  0 = conventional, 1 = bit-reversed; sampled at global period boundary
out  out  CHANNELS  PWM bit streams, registered
period_start  out  1  registered strobe, high for the cycle in which out shows global phase 0

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values: cnt=0; all shadow and active duty registers=0; active mode=0; out=0; period_start=0; wr_ready=0 while rst=1, 1 otherwise.
- Global counter cnt (BITS wide):
  - increments by 1 every clk and wraps P-1 -> 0
  - channel counter cnt_k = (cnt + k*P/CHANNELS) mod P when STAGGER=1, else cnt
- Compare index m_k:
  - active mode 0: m_k = cnt_k
  - active mode 1: m_k = bit-reverse of cnt_k; for BITS=3 the sequence is 0,4,2,6,1,5,3,7
- Output: out[k] registered each edge as (active_k > m_k), comparison in BITS+1 bits.
  - out lags cnt by exactly 1 cycle
  - active_k = P gives constant 1; active_k = 0 gives constant 0
- Write port:
  - accepted write loads shadow_ch = min(wr_data, P) on the next edge
  - wr_ready is combinationally 1 outside reset; there is no backpressure
  - multiple writes to one channel within a period: last one wins
- Reload:
  - active_k <= shadow_k on the edge where cnt_k goes P-1 -> 0, so each channel changes only at its own period boundary (no runt pulses)
  - bypass: an accepted write to channel k in the same cycle as its reload loads active_k directly with the saturated wr_data
- Mode:
  - active mode <= mode on the edge where global cnt goes P-1 -> 0
  - with STAGGER=1, the new mode applies to all channels from that edge, including mid-period for offset channels; this is accepted behaviour
- period_start: registered; = 1 on the edge following the cycle with cnt==0, so it is aligned with out.
- Reset mid-operation: all state returns to reset values on the next edge regardless of write activity. The first period after reset starts at cnt=0 with duty 0.
- Latency: write at edge t is visible in shadow at t+1, in active at the next own boundary, and on out one cycle after that.

Decomposition:
- Package pwm_pkg:
  - MODE_LINEAR=0, MODE_BITREV=1
  - function bit_rev(value, width)
  - function sat_duty(code, BITS)
- Sub-module pwm_pr_chan, one per channel:
  - contents: shadow register, active register, reload/bypass logic, index mangling, comparator, out flop
  - inputs from top: cnt_k, reload strobe, active mode, write strobe
- Top contains: global counter, stagger offsets, mode register, period_start, write decode.

Test Plan:
1. BITS=3, mode=1, write ch0=2, wait for boundary -> out[0] per period 1,0,0,0,1,0,0,0.
2. mode=0, ch1=3 -> out[1] = 1,1,1,0,0,0,0,0; switch mode to 1 mid-period -> ordering changes only from the next cnt=0.
3. ch2=8 -> out[2] constant 1; ch2=12 -> shadow=8, constant 1; ch3=0 -> constant 0.
4. Writes of 5 then 1 to ch0 within one period -> next period uses 1. Write 6 exactly when cnt==7 -> next period uses 6 (bypass).
5. STAGGER=1, CHANNELS=4, all duty 4, mode 0 -> rising edges of out[0..3] 2 cycles apart; each channel switches duty only at its own wrap.
6. Assert rst for 1 cycle mid-period with wr_valid=1 -> out=0, period_start=0, wr_ready=0 during reset, write ignored; period_start first pulses 1 cycle after cnt returns to 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel pseudo-random PWM.
package pwm_pkg;

    localparam logic MODE_LINEAR = 1'b0;
    localparam logic MODE_BITREV = 1'b1;

    function automatic logic [31:0] bit_rev(input logic [31:0] value,
                                            input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) r[width-1-i] = value[i];
        end
        return r;
    endfunction

    function automatic logic [31:0] sat_duty(input logic [31:0] code,
                                             input int bits);
        logic [31:0] p;
        p = 32'd1 << bits;
        return (code > p) ? p : code;
    endfunction

endpackage

// File: rtl/pwm_pr_chan.sv
// One PWM channel: double-buffered duty, index ordering and output flop.
module pwm_pr_chan
    import pwm_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [BITS-1:0] cnt_i,
    input  logic            reload_i,
    input  logic            mode_i,
    input  logic            wr_en_i,
    input  logic [BITS:0]   wr_duty_i,
    output logic            out_o
);

    logic [BITS:0]   shadow_q, shadow_d;
    logic [BITS:0]   active_q, active_d;
    logic            out_q, out_d;
    logic [BITS-1:0] idx;

    always_comb begin
        shadow_d = wr_en_i ? wr_duty_i : shadow_q;
        active_d = active_q;
        // A write landing on the reload edge goes straight to active
        if (reload_i) active_d = wr_en_i ? wr_duty_i : shadow_q;
        idx = (mode_i == MODE_BITREV)
            ? BITS'(bit_rev(32'(cnt_i), BITS))
            : cnt_i;
        out_d = (active_q > {1'b0, idx});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= '0;
            active_q <= '0;
            out_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            out_q    <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/pwm_pr_multi.sv
// Multi-channel PWM with linear or bit-reversed ordering and optional
// per-channel phase staggering.
module pwm_pr_multi
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int BITS     = 4,
    parameter int STAGGER  = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [BITS:0]               wr_data_i,
    input  logic [$clog2(CHANNELS)-1:0] wr_ch_i,
    input  logic                        wr_valid_i,
    output logic                        wr_ready_o,
    input  logic                        mode_i,
    output logic [CHANNELS-1:0]         out_o,
    output logic                        period_start_o
);

    localparam int P   = 1 << BITS;
    localparam int CHW = $clog2(CHANNELS);

    logic [BITS-1:0] cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic            ps_q, ps_d;
    logic            wr_fire;
    logic [BITS:0]   wr_duty;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        mode_d = (cnt_q == BITS'(P - 1)) ? mode_i : mode_q;
        ps_d   = (cnt_q == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            mode_q <= MODE_LINEAR;
            ps_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            ps_q   <= ps_d;
        end
    end

    assign wr_ready_o     = ~rst_i;
    assign wr_fire        = wr_valid_i & wr_ready_o;
    assign wr_duty        = (BITS+1)'(sat_duty(32'(wr_data_i), BITS));
    assign period_start_o = ps_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        localparam int OFF = (STAGGER != 0) ? (k * (P / CHANNELS)) % P : 0;

        logic [BITS-1:0] cnt_k;
        logic            reload_k;
        logic            wr_en_k;

        assign cnt_k    = cnt_q + BITS'(OFF);
        assign reload_k = (cnt_k == BITS'(P - 1));
        assign wr_en_k  = wr_fire && (wr_ch_i == CHW'(k));

        pwm_pr_chan #(
            .BITS(BITS)
        ) u_chan (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .cnt_i    (cnt_k),
            .reload_i (reload_k),
            .mode_i   (mode_q),
            .wr_en_i  (wr_en_k),
            .wr_duty_i(wr_duty),
            .out_o    (out_o[k])
        );
    end

endmodule
